// File: rtl/pika_pkg.sv
// rtl/pika_pkg.sv - shared game state encodings and playfield geometry
package pika_pkg;

  typedef enum logic [1:0] {
    GS_START = 2'd0,
    GS_WAIT  = 2'd1,
    GS_PLAY  = 2'd2,
    GS_END   = 2'd3
  } game_state_t;

  localparam int VBUF_W          = 320;
  localparam int VBUF_H          = 240;
  localparam int BALL_W          = 30;
  localparam int BALL_H          = 30;
  localparam int FLOOR_MARGIN    = 20;
  localparam int NET_POS_X       = 160;
  localparam int NET_W           = 6;
  localparam bit PLAYER_ON_RIGHT = 1'b1;

  localparam int DEF_WIN_SCORE     = 5;
  localparam int DEF_DROP_WAIT_CYC = 50_000_000;

  localparam int FLOOR_Y    = VBUF_H - FLOOR_MARGIN;
  localparam int NET_CENTRE = NET_POS_X + NET_W / 2;

endpackage

// File: rtl/serve_timer.sv
// rtl/serve_timer.sv - serve-wait up-counter with clear/enable and terminal-count flag
module serve_timer #(
  parameter int W        = 32,
  parameter int TC_VALUE = 49_999_999
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [W-1:0] count;

  // Count up while enabled; clear has priority so a new wait always starts at zero
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(TC_VALUE));

endmodule

// File: rtl/game_referee.sv
// rtl/game_referee.sv - rally referee: landing detection, scoring and match FSM
module game_referee
  import pika_pkg::*;
#(
  parameter int DROP_WAIT_CYC = DEF_DROP_WAIT_CYC,
  parameter int WIN_SCORE     = DEF_WIN_SCORE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  game_state_t state, state_n;
  logic        btn_q;
  logic        armed, armed_n;
  logic        who_win_n;
  logic        point_pulse_n;
  logic [3:0]  player_score_n, npc_score_n;
  logic        timer_tc;

  logic        start_edge;
  logic [11:0] ball_bottom;
  logic [11:0] ball_centre;
  logic        landed;
  logic        ball_right;
  logic        point_to_npc;
  logic [3:0]  player_inc, npc_inc, winner_new;

  assign start_edge  = start_btn & ~btn_q;
  assign ball_bottom = Ball_Y + 12'(BALL_H);
  assign ball_centre = Ball_X + 12'(BALL_W / 2);
  assign landed      = (ball_bottom >= 12'(FLOOR_Y));
  // Exact centre on the net midline is treated as the right court
  assign ball_right  = (ball_centre >= 12'(NET_CENTRE));
  // Ball on the player's court means the player failed to return it
  assign point_to_npc = (ball_right == PLAYER_ON_RIGHT);

  assign player_inc = (player_score < 4'(WIN_SCORE)) ? player_score + 4'd1 : player_score;
  assign npc_inc    = (npc_score    < 4'(WIN_SCORE)) ? npc_score    + 4'd1 : npc_score;
  assign winner_new = point_to_npc ? npc_inc : player_inc;

  serve_timer #(
    .W        (32),
    .TC_VALUE (DROP_WAIT_CYC - 1)
  ) u_serve_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state != GS_WAIT) || (state_n != GS_WAIT)),
    .enable (state == GS_WAIT),
    .tc     (timer_tc)
  );

  // Register match state, scores and button history
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= GS_START;
      btn_q        <= 1'b0;
      armed        <= 1'b0;
      who_win      <= 1'b0;
      point_pulse  <= 1'b0;
      player_score <= 4'd0;
      npc_score    <= 4'd0;
    end else begin
      state        <= state_n;
      btn_q        <= start_btn;
      armed        <= armed_n;
      who_win      <= who_win_n;
      point_pulse  <= point_pulse_n;
      player_score <= player_score_n;
      npc_score    <= npc_score_n;
    end
  end

  // Next-state and scoring decisions for the match FSM
  always_comb begin
    state_n        = state;
    armed_n        = armed;
    who_win_n      = who_win;
    point_pulse_n  = 1'b0;
    player_score_n = player_score;
    npc_score_n    = npc_score;
    case (state)
      GS_START, GS_END: begin
        if (start_edge) begin
          player_score_n = 4'd0;
          npc_score_n    = 4'd0;
          who_win_n      = 1'b0;
          state_n        = GS_WAIT;
        end
      end
      GS_WAIT: begin
        if (timer_tc) begin
          state_n = GS_PLAY;
          armed_n = 1'b0;
        end
      end
      GS_PLAY: begin
        if (armed && landed) begin
          point_pulse_n = 1'b1;
          armed_n       = 1'b0;
          who_win_n     = point_to_npc;
          if (point_to_npc) begin
            npc_score_n = npc_inc;
          end else begin
            player_score_n = player_inc;
          end
          state_n = (winner_new == 4'(WIN_SCORE)) ? GS_END : GS_WAIT;
        end else if (!landed) begin
          // Arm only after the ball is seen airborne, so a stale floor position is ignored
          armed_n = 1'b1;
        end
      end
      default: state_n = GS_START;
    endcase
  end

  assign Game_state = state;

endmodule

// File: tb/tb_game_referee.sv
// tb/tb_game_referee.sv - randomized and directed self-checking bench for game_referee
module tb_game_referee;

  localparam int DW  = 4;
  localparam int WIN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic [11:0] Ball_X;
  logic [11:0] Ball_Y;
  logic [1:0]  Game_state;
  logic        who_win;
  logic [3:0]  player_score;
  logic [3:0]  npc_score;
  logic        point_pulse;

  int checks   = 0;
  int failures = 0;

  // reference model (rules of the game in plain integers)
  int m_state, m_timer, m_ps, m_ns, m_who, m_pulse;
  bit m_armed, m_btn_q;

  game_referee #(.DROP_WAIT_CYC(DW), .WIN_SCORE(WIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .Ball_X       (Ball_X),
    .Ball_Y       (Ball_Y),
    .Game_state   (Game_state),
    .who_win      (who_win),
    .player_score (player_score),
    .npc_score    (npc_score),
    .point_pulse  (point_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit edge_seen, landed, on_right;
    if (reset) begin
      m_state = 0; m_timer = 0; m_ps = 0; m_ns = 0; m_who = 0; m_pulse = 0;
      m_armed = 0; m_btn_q = 0;
      return;
    end
    edge_seen = start_btn && !m_btn_q;
    m_pulse = 0;
    if (m_state == 0 || m_state == 3) begin
      if (edge_seen) begin
        m_ps = 0; m_ns = 0; m_who = 0; m_timer = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_timer == DW - 1) begin
        m_state = 2; m_timer = 0; m_armed = 0;
      end else begin
        m_timer++;
      end
    end else begin
      landed   = ((int'(Ball_Y) + 30) % 4096) >= 220;
      on_right = ((int'(Ball_X) + 15) % 4096) >= 163;
      if (m_armed && landed) begin
        m_pulse = 1; m_armed = 0; m_timer = 0;
        if (on_right) begin
          m_who = 1;
          if (m_ns < WIN) m_ns++;
          m_state = (m_ns == WIN) ? 3 : 1;
        end else begin
          m_who = 0;
          if (m_ps < WIN) m_ps++;
          m_state = (m_ps == WIN) ? 3 : 1;
        end
      end else if (!landed) begin
        m_armed = 1;
      end
    end
    m_btn_q = start_btn;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".state"},  int'(Game_state),   m_state);
    check({tag, ".who"},    int'(who_win),      m_who);
    check({tag, ".pscore"}, int'(player_score), m_ps);
    check({tag, ".nscore"}, int'(npc_score),    m_ns);
    check({tag, ".pulse"},  int'(point_pulse),  m_pulse);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic land(input string tag, input int x, input int y);
    Ball_Y = 12'd60;
    step({tag, ".air"});
    Ball_X = 12'(x);
    Ball_Y = 12'(y);
    step({tag, ".land"});
    Ball_Y = 12'd60;
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; Ball_X = 12'd50; Ball_Y = 12'd60;
    run("reset", 2);
    check("reset_state_const", int'(Game_state), 0);
    reset = 1'b0;

    start_btn = 1'b1;
    run("start_hold", 10);
    check("start_reached_play", int'(Game_state), 2);
    start_btn = 1'b0;

    land("npc_point", 200, 190);
    check("npc_point_score", int'(npc_score), 1);
    Ball_Y = 12'd190;
    run("held_floor", 8);
    check("held_floor_no_point", int'(npc_score), 1);

    land("player_pt1", 100, 195);
    run("wait1", 5);
    start_btn = 1'b1;
    land("player_pt2", 100, 195);
    check("match_end", int'(Game_state), 3);
    land("end_ignored", 100, 195);
    run("end_level", 3);
    start_btn = 1'b0;
    step("end_release");
    start_btn = 1'b1;
    step("restart");
    check("restart_scores", int'(player_score), 0);
    start_btn = 1'b0;

    run("wait2", 5);
    land("centre_left", 135, 195);
    run("wait3", 5);
    land("centre_exact", 148, 195);

    run("wait4", 2);
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;

    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start_btn = ($urandom_range(0, 9) == 0);
      Ball_X    = 12'($urandom_range(0, 319));
      Ball_Y    = ($urandom_range(0, 2) == 0) ? 12'($urandom_range(185, 239))
                                              : 12'($urandom_range(0, 195));
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
